// File: rtl/ps2_kbd_ctrl_if.sv
// Key-event handshake bundle between the PS/2 controller and its consumer.
//   key_valid : head event available (controller -> consumer)
//   key_ready : consumer accepts the head event (consumer -> controller)
//   key_code  : scan code of head event
//   key_break : head event was a release (F0 prefix seen)
//   key_ext   : head event was an extended key (E0 prefix seen)
interface ps2_kbd_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_code;
  logic       key_break;
  logic       key_ext;

  modport master (output key_valid, key_code, key_break, key_ext, input key_ready);
  modport slave  (input key_valid, key_code, key_break, key_ext, output key_ready);
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard receive controller.
// Synchronises and de-glitches ps2c/ps2d, assembles 11-bit frames (start, 8 data
// LSB-first, odd parity, stop), folds E0/F0 prefixes into key events and queues
// the events in a small FIFO drained over a valid/ready handshake.
// Ports:
//   clk, reset     : system clock, synchronous active-high reset
//   ps2d, ps2c     : asynchronous PS/2 data/clock lines
//   rx_en          : receive enable (0 parks the frame FSM in IDLE)
//   key            : event handshake (master side)
//   err_parity     : 1-cycle pulse, frame failed odd parity
//   err_frame      : 1-cycle pulse, bad stop bit or inter-edge timeout
//   overflow       : 1-cycle pulse, event dropped because FIFO was full
module ps2_kbd_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ps2d,
  input  logic           ps2c,
  input  logic           rx_en,
  ps2_kbd_ctrl_if.master key,
  output logic           err_parity,
  output logic           err_frame,
  output logic           overflow
);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input path ----------------
  logic [1:0]     c_sync_q, d_sync_q;
  logic           filt_q, filt_prev_q;
  logic [FCW-1:0] flt_cnt_q;
  logic           fall, din;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q    <= 2'b11;
      d_sync_q    <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      c_sync_q    <= {c_sync_q[0], ps2c};
      d_sync_q    <= {d_sync_q[0], ps2d};
      filt_prev_q <= filt_q;
      // Count consecutive samples that disagree with the filtered level; any
      // agreeing sample restarts the run, so short glitches never propagate.
      if (c_sync_q[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_q    <= c_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FCW'(1);
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;
  assign din  = d_sync_q[1];

  // ---------------- frame FSM ----------------
  state_t         state_q, state_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic           par_q, par_d;
  logic [TOW-1:0] to_q, to_d;
  logic           byte_done, perr, ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_d     = par_q;
    to_d      = (state_q == S_IDLE || fall) ? '0 : to_q + TOW'(1);
    byte_done = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (!rx_en) begin
      state_d = S_IDLE;
      to_d    = '0;
    end else if (state_q != S_IDLE && !fall && to_q == TOW'(TIMEOUT_CYCLES - 1)) begin
      // Keyboard stalled mid-frame: drop the partial byte.
      state_d = S_IDLE;
      ferr    = 1'b1;
      to_d    = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: if (!din) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
        S_DATA: begin
          data_d[bit_q] = din;
          bit_d         = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = din;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!din)                 ferr      = 1'b1;
          else if (^data_q ^ par_q) byte_done = 1'b1;
          else                      perr      = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- prefix decoder + FIFO ----------------
  logic           ext_q, ext_d, brk_q, brk_d;
  logic [9:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  fcnt_q;
  logic           push, pop, full, wr_en, valid;

  assign push  = byte_done && data_q != 8'hE0 && data_q != 8'hF0;
  assign valid = (fcnt_q != '0);
  assign full  = (fcnt_q == CW'(FIFO_DEPTH));
  assign pop   = valid & key.key_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en = push & (~full | pop);

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    if (perr || ferr) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done) begin
      if (data_q == 8'hE0)      ext_d = 1'b1;
      else if (data_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      fcnt_q     <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      err_parity <= perr;
      err_frame  <= ferr;
      overflow   <= push & full & ~pop;
      if (wr_en) wr_q <= wr_q + PW'(1);
      if (pop)   rd_q <= rd_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {ext_q, brk_q, data_q};
  end

  assign key.key_valid = valid;
  assign key.key_code  = valid ? mem_q[rd_q][7:0] : 8'h00;
  assign key.key_break = valid & mem_q[rd_q][8];
  assign key.key_ext   = valid & mem_q[rd_q][9];
endmodule
